// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: state codes,
// op_class codes and a helper that classifies the unit-driving states.
package mips_ctrl_pkg;

    localparam int OPC_W = 3;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_BRANCH = 4'd5,
        S_WB     = 4'd6,
        S_HALTED = 4'd7,
        S_FAULT  = 4'd8
    } state_t;

    localparam logic [OPC_W-1:0] OP_ALU    = 3'd0;
    localparam logic [OPC_W-1:0] OP_LOAD   = 3'd1;
    localparam logic [OPC_W-1:0] OP_STORE  = 3'd2;
    localparam logic [OPC_W-1:0] OP_BRANCH = 3'd3;
    localparam logic [OPC_W-1:0] OP_JUMP   = 3'd4;
    localparam logic [OPC_W-1:0] OP_HALT   = 3'd5;

    function automatic logic is_stage(input state_t s);
        return (s == S_FETCH) || (s == S_DECODE) || (s == S_EXEC) ||
               (s == S_MEM) || (s == S_BRANCH) || (s == S_WB);
    endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage cycle counter: cleared on state entry, counts while a stage is
// active and flags expiry in the TIMEOUT-th cycle of the stage.
module stage_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = run && (cnt == LAST);

endmodule

// File: rtl/multicycle_stage_sequencer.sv
// Multicycle MIPS control FSM: steps the stage units one at a time through an
// enable/done handshake, retires instructions and traps hung stages.
module multicycle_stage_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic [OPC_W-1:0] op_class,
    input  logic             fetch_done,
    input  logic             decode_done,
    input  logic             exec_done,
    input  logic             mem_done,
    input  logic             branch_done,
    input  logic             wb_done,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             branch_en,
    output logic             wb_en,
    output logic             pc_write,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_dbg
);

    state_t           state;
    state_t           state_nx;
    logic [OPC_W-1:0] opc;
    logic             fresh;
    logic             cur_done;
    logic             accept;
    logic             retire;
    logic             expired;

    stage_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_nx != state),
        .run     (is_stage(state)),
        .expired (expired)
    );

    always_comb begin
        cur_done = 1'b0;
        case (state)
            S_FETCH:  cur_done = fetch_done;
            S_DECODE: cur_done = decode_done;
            S_EXEC:   cur_done = exec_done;
            S_MEM:    cur_done = mem_done;
            S_BRANCH: cur_done = branch_done;
            S_WB:     cur_done = wb_done;
            default:  cur_done = 1'b0;
        endcase
    end

    // First cycle of a stage masks done left over from the previous request.
    assign accept = is_stage(state) && !fresh && cur_done;

    always_comb begin
        state_nx = state;
        retire   = 1'b0;
        case (state)
            S_IDLE:   if (start) state_nx = S_FETCH;
            S_FETCH:  if (accept) state_nx = S_DECODE;
            S_DECODE: begin
                if (accept) begin
                    case (op_class)
                        OP_ALU, OP_LOAD, OP_STORE, OP_BRANCH: state_nx = S_EXEC;
                        OP_JUMP:                              state_nx = S_BRANCH;
                        OP_HALT:                              state_nx = S_HALTED;
                        default:                              state_nx = S_FAULT;
                    endcase
                end
            end
            S_EXEC: begin
                if (accept) begin
                    case (opc)
                        OP_LOAD, OP_STORE: state_nx = S_MEM;
                        OP_BRANCH:         state_nx = S_BRANCH;
                        default:           state_nx = S_WB;
                    endcase
                end
            end
            S_MEM: begin
                if (accept) begin
                    if (opc == OP_LOAD) state_nx = S_WB;
                    else                retire   = 1'b1;
                end
            end
            S_BRANCH, S_WB: if (accept) retire = 1'b1;
            default: state_nx = state;
        endcase
        if (retire) state_nx = halt_req ? S_IDLE : S_FETCH;
        if (expired && !accept) state_nx = S_FAULT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            opc         <= '0;
            fresh       <= 1'b0;
            instr_count <= '0;
            fetch_en    <= 1'b0;
            decode_en   <= 1'b0;
            exec_en     <= 1'b0;
            mem_en      <= 1'b0;
            branch_en   <= 1'b0;
            wb_en       <= 1'b0;
            pc_write    <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state <= state_nx;
            fresh <= (state_nx != state);
            if ((state == S_DECODE) && accept) opc <= op_class;
            if (retire) instr_count <= instr_count + 1'b1;
            fetch_en  <= (state_nx == S_FETCH);
            decode_en <= (state_nx == S_DECODE);
            exec_en   <= (state_nx == S_EXEC);
            mem_en    <= (state_nx == S_MEM);
            branch_en <= (state_nx == S_BRANCH);
            wb_en     <= (state_nx == S_WB);
            pc_write  <= retire;
            busy      <= is_stage(state_nx);
            fault     <= (state_nx == S_FAULT);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_stage_sequencer.sv
// Directed and randomized bench for multicycle_stage_sequencer; expected stage
// walks come from a per-op_class path table and a retired-instruction tally.
module tb_multicycle_stage_sequencer;

    localparam int ST_F = 5, ST_D = 4, ST_E = 3, ST_M = 2, ST_B = 1, ST_W = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic [2:0]  op_class;
    logic [5:0]  done_v;
    logic [5:0]  en_v;
    logic        fetch_en, decode_en, exec_en, mem_en, branch_en, wb_en;
    logic        pc_write, busy, fault;
    logic [31:0] instr_count;
    logic [3:0]  state_dbg;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_cnt;
    logic        exp_pw;
    logic [5:0]  linger_v;
    bit          idle;

    always #5 clk = ~clk;

    multicycle_stage_sequencer #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .halt_req    (halt_req),
        .op_class    (op_class),
        .fetch_done  (done_v[ST_F]),
        .decode_done (done_v[ST_D]),
        .exec_done   (done_v[ST_E]),
        .mem_done    (done_v[ST_M]),
        .branch_done (done_v[ST_B]),
        .wb_done     (done_v[ST_W]),
        .fetch_en    (fetch_en),
        .decode_en   (decode_en),
        .exec_en     (exec_en),
        .mem_en      (mem_en),
        .branch_en   (branch_en),
        .wb_en       (wb_en),
        .pc_write    (pc_write),
        .busy        (busy),
        .fault       (fault),
        .instr_count (instr_count),
        .state_dbg   (state_dbg)
    );

    assign en_v = {fetch_en, decode_en, exec_en, mem_en, branch_en, wb_en};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        halt_req = 1'b0;
        op_class = '0;
        done_v   = '0;
        linger_v = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = '0;
        exp_pw  = 1'b0;
        idle    = 1'b1;
    endtask

    task automatic go();
        start    = 1'b1;
        done_v   = '0;
        linger_v = '0;
        @(negedge clk);
        start  = 1'b0;
        idle   = 1'b0;
        exp_pw = 1'b0;
    endtask

    // Called at the falling edge inside the first cycle of stage stg.
    task automatic do_stage(input int stg, input int lat, input bit stale, input bit fin,
                            input bit hreq, input bit bm, input logic [2:0] opc);
        logic [5:0] onehot;
        onehot = 6'b1 << stg;
        for (int c = 1; c <= lat; c++) begin
            chk("stage_en", en_v, onehot);
            if (c == 1) begin
                chk("pc_write_entry", pc_write, exp_pw);
                exp_pw = 1'b0;
                chk("busy_stage", busy, 1);
            end else begin
                chk("pc_write_mid", pc_write, 0);
            end
            done_v = '0;
            if (c == 1) done_v = linger_v | (stale ? onehot : 6'b0);
            if (c == lat) done_v = done_v | onehot;
            halt_req = (fin && c == lat) ? hreq : 1'($urandom);
            op_class = (c == lat) ? opc : 3'($urandom);
            @(negedge clk);
        end
        linger_v = bm ? onehot : 6'b0;
        done_v   = linger_v;
    endtask

    task automatic run_instr(input int op, input bit halt, input int lat_fix, input bit bm);
        int path[$];
        int lat;
        bit ret;
        if (idle) go();
        path = {ST_F, ST_D};
        case (op)
            0: path = {path, ST_E, ST_W};
            1: path = {path, ST_E, ST_M, ST_W};
            2: path = {path, ST_E, ST_M};
            3: path = {path, ST_E, ST_B};
            4: path = {path, ST_B};
            default: ;
        endcase
        ret = (op <= 4);
        foreach (path[i]) begin
            lat = (lat_fix != 0) ? lat_fix : $urandom_range(2, 5);
            do_stage(path[i], lat, (lat_fix == 0) && 1'($urandom),
                     ret && (i == path.size() - 1), halt, bm,
                     (path[i] == ST_D) ? 3'(op) : 3'($urandom));
        end
        if (ret) begin
            exp_cnt = exp_cnt + 1;
            chk("instr_count", instr_count, exp_cnt);
            if (halt) begin
                chk("pc_write_halt_retire", pc_write, 1);
                chk("idle_en", en_v, 0);
                chk("idle_busy", busy, 0);
                chk("idle_state", state_dbg, 0);
                idle   = 1'b1;
                exp_pw = 1'b0;
            end else begin
                exp_pw = 1'b1;
            end
        end else begin
            chk("halted_en", en_v, 0);
            chk("halted_busy", busy, 0);
            chk("halted_fault", fault, 0);
            chk("halted_pc_write", pc_write, 0);
            chk("halted_count", instr_count, exp_cnt);
            start = 1'b1;
            repeat (3) @(negedge clk);
            start = 1'b0;
            chk("halted_start_ignored", en_v, 0);
            chk("halted_stays_idle_busy", busy, 0);
        end
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        start    = 1'b0;
        halt_req = 1'b0;
        op_class = '0;
        done_v   = '0;
        linger_v = '0;
        exp_cnt  = '0;
        exp_pw   = 1'b0;
        idle     = 1'b1;

        // Reset state
        do_reset();
        chk("rst_en", en_v, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_state", state_dbg, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        chk("rst_pc_write", pc_write, 0);

        // ALU, every done one cycle after en rises
        run_instr(0, 1'b0, 2, 1'b0);
        chk("alu_fetch_again", en_v, 6'b1 << ST_F);
        chk("alu_pc_write", pc_write, 1);

        // Three branches with done lingering one cycle after en falls
        for (int i = 0; i < 3; i++) run_instr(3, 1'b0, 2, 1'b1);
        chk("branch_count", instr_count, 4);

        // LOAD then STORE
        run_instr(1, 1'b0, 2, 1'b0);
        run_instr(2, 1'b0, 3, 1'b0);
        chk("ldst_count", instr_count, 6);

        // halt_req at retire returns to IDLE; HALT op stops without retiring
        run_instr(0, 1'b1, 0, 1'b0);
        run_instr(5, 1'b0, 2, 1'b0);

        // Randomized instruction stream
        do_reset();
        for (int i = 0; i < 30; i++)
            run_instr($urandom_range(0, 4), ($urandom_range(0, 3) == 0), 0, 1'($urandom));

        // Done in the last allowed cycle wins over the watchdog
        do_reset();
        go();
        do_stage(ST_F, 2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        do_stage(ST_D, 2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        do_stage(ST_E, 16, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        chk("wd_boundary_no_fault", fault, 0);
        do_stage(ST_W, 2, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        chk("wd_boundary_count", instr_count, 1);
        chk("wd_boundary_fetch", en_v, 6'b1 << ST_F);

        // Hung EXEC -> FAULT after 16 cycles
        do_reset();
        go();
        do_stage(ST_F, 2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        do_stage(ST_D, 2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        done_v = '0;
        n = 0;
        while (exec_en === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("wd_exec_cycles", n, 16);
        chk("wd_fault", fault, 1);
        chk("wd_en", en_v, 0);
        chk("wd_busy", busy, 0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        chk("wd_fault_sticky", fault, 1);
        chk("wd_start_ignored", en_v, 0);

        // Illegal op_class
        do_reset();
        go();
        do_stage(ST_F, 2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        do_stage(ST_D, 2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6);
        chk("illegal_fault", fault, 1);
        chk("illegal_en", en_v, 0);
        chk("illegal_busy", busy, 0);

        // Reset while in MEM
        do_reset();
        run_instr(0, 1'b0, 2, 1'b0);
        do_stage(ST_F, 2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        do_stage(ST_D, 2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        do_stage(ST_E, 2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        chk("mem_reached", en_v, 6'b1 << ST_M);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_en", en_v, 0);
        chk("midrst_count", instr_count, 0);
        chk("midrst_state", state_dbg, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_pc_write", pc_write, 0);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL tb_timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
